// File: rtl/ripple_count_capture_if.sv
// Interface bundling the count path of ripple_count_capture.
// Ports: count_in/clear flow from the driving side (master) to the capture block (slave);
//        count_out, count_valid, change, wrap, wrap_count and hex flow back.
interface ripple_count_capture_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  count_in;
  logic              clear;
  logic [WIDTH-1:0]  count_out;
  logic              count_valid;
  logic              change;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_count;
  logic [6:0]        hex;

  modport master (
    output count_in, clear,
    input  count_out, count_valid, change, wrap, wrap_count, hex
  );

  modport slave (
    input  count_in, clear,
    output count_out, count_valid, change, wrap, wrap_count, hex
  );
endinterface

// File: rtl/ripple_count_capture.sv
// Captures a 4-bit asynchronous ripple count into the clk domain: two-flop synchroniser,
// run-length stability filter, clean count with change/wrap pulses, saturating wrap tally
// and an active-low 7-segment code. Ports: clk, reset (async, active low), bus (slave):
// count_in/clear in; count_out/count_valid/change/wrap/wrap_count/hex out.
module ripple_count_capture #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3,   // must be >= 2
  parameter int WRAP_W        = 8
) (
  input logic                  clk,
  input logic                  reset,
  ripple_count_capture_if.slave bus
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_ACC  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [WRAP_W-1:0] WRAP_SAT = '1;

  logic [WIDTH-1:0]  s1, s2;
  logic [WIDTH-1:0]  cand;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  count_out_q;
  logic              count_valid_q;
  logic              change_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wrap_count_q;

  logic accept;
  logic is_new;
  logic is_wrap;
  logic [3:0] nib;
  logic [6:0] seg;

  // cnt saturates at STABLE_CYCLES, so the exact SC-1 match fires only once per run.
  always_comb begin
    accept  = (s2 == cand) && (cnt == CNT_ACC);
    is_new  = !count_valid_q || (cand != count_out_q);
    is_wrap = count_valid_q && (cand < count_out_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1            <= '0;
      s2            <= '0;
      cand          <= '0;
      cnt           <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      change_q      <= 1'b0;
      wrap_q        <= 1'b0;
      wrap_count_q  <= '0;
    end else begin
      s1 <= bus.count_in;
      s2 <= s1;

      if (s2 != cand) begin
        cand <= s2;
        cnt  <= CNT_ONE;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      change_q <= 1'b0;
      wrap_q   <= 1'b0;

      // clear overrides an accept on the same edge; cnt restart (placed after the
      // filter update) means a steady input re-accepts STABLE_CYCLES edges later.
      if (bus.clear) begin
        count_valid_q <= 1'b0;
        wrap_count_q  <= '0;
        cnt           <= '0;
      end else if (accept) begin
        count_out_q   <= cand;
        count_valid_q <= 1'b1;
        change_q      <= is_new;
        wrap_q        <= is_wrap;
        if (is_wrap && (wrap_count_q != WRAP_SAT))
          wrap_count_q <= wrap_count_q + 1'b1;
      end
    end
  end

  // Active-low {g,f,e,d,c,b,a}; blank whenever no value is currently valid.
  always_comb begin
    nib = count_out_q[3:0];
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
    if (!count_valid_q)
      seg = 7'h7F;
  end

  assign bus.count_out   = count_out_q;
  assign bus.count_valid = count_valid_q;
  assign bus.change      = change_q;
  assign bus.wrap        = wrap_q;
  assign bus.wrap_count  = wrap_count_q;
  assign bus.hex         = seg;

endmodule
